bus_responder: RTL and testbench

BUS_RESPONDER -- requirements
Module: bus_responder

---
 rtl/bus_responder.sv | 131 +++++++++++++
 tb/tb_bus_responder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bus_responder.sv
// Four-phase register-file responder with WAIT_CYCLES wait states before ack; err pulses on an aborted transfer.
// Optional BUS_RESPONDER_RO_ID_EN: index 0 becomes a read-only ID of alternating 1010 bits from the MSB.
module bus_responder #(
  parameter int DW          = 8,
  parameter int AW          = 2,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic          err
);

  localparam int         NREG     = 1 << AW;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          ack_nxt, err_nxt;
  logic          latch, fire;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] rd_val;
  logic          wr_ok;

`ifdef BUS_RESPONDER_RO_ID_EN
  function automatic logic [DW-1:0] id_pattern();
    logic [DW-1:0] p;
    for (int i = 0; i < DW; i++) p[i] = ((DW - 1 - i) % 2) == 0;
    return p;
  endfunction
  localparam logic [DW-1:0] ID_PAT = id_pattern();

  always_comb begin
    rd_val = (addr_q == '0) ? ID_PAT : regs[addr_q];
    wr_ok  = we_q && (addr_q != '0);
  end
`else
  always_comb begin
    rd_val = regs[addr_q];
    wr_ok  = we_q;
  end
`endif

  // ack is registered, so it rises on the first edge spent in ACK; that edge also commits the access.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_nxt   = ack;
    err_nxt   = 1'b0;
    latch     = 1'b0;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          latch     = 1'b1;
          cnt_nxt   = CNT_INIT;
          state_nxt = (WAIT_CYCLES > 0) ? WAIT : ACK;
        end
      end
      WAIT: begin
        if (!req) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
          err_nxt   = 1'b1;
        end else if (cnt == 4'd1) begin
          state_nxt = ACK;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ACK: begin
        if (!req) begin
          state_nxt = IDLE;
          ack_nxt   = 1'b0;
          // req withdrawn before ack was ever seen is still an abort
          err_nxt   = !ack;
        end else if (!ack) begin
          ack_nxt = 1'b1;
          fire    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ack   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack   <= ack_nxt;
      err   <= err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (latch) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (fire) begin
        if (wr_ok) regs[addr_q] <= wdata_q;
        if (!we_q) rdata <= rd_val;
      end
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: one instance with WAIT_CYCLES=2 and one with 0, sharing stimulus.
module tb_bus_responder;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, req, we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic       ack_w, err_w, ack_z, err_z;
  logic [7:0] rdata_w, rdata_z;
  logic       sel_z;

  int checks   = 0;
  int failures = 0;

`ifdef BUS_RESPONDER_RO_ID_EN
  localparam logic [7:0] REG0_RST = 8'hAA;
  localparam logic [7:0] REG0_WR  = 8'hAA;
`else
  localparam logic [7:0] REG0_RST = 8'h00;
  localparam logic [7:0] REG0_WR  = 8'h55;
`endif

  bus_responder #(.DW(8), .AW(2), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack_w), .rdata(rdata_w), .err(err_w)
  );

  bus_responder #(.DW(8), .AW(2), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack_z), .rdata(rdata_z), .err(err_z)
  );

  wire       ack_s   = sel_z ? ack_z : ack_w;
  wire       err_s   = sel_z ? err_z : err_w;
  wire [7:0] rdata_s = sel_z ? rdata_z : rdata_w;

  // One full transfer on the selected instance; lat = edges after accept edge N until ack seen (-1 on timeout).
  task automatic xfer(input logic w, input logic [1:0] a, input logic [7:0] d,
                      output int lat, output logic [7:0] rd, output logic errs, output logic ack_low);
    int k;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    lat = -1; errs = 1'b0; k = 0;
    while (lat < 0 && k < 20) begin
      if (k > 0) @(posedge clk);
      #1;
      if (ack_s) lat = k;
      else errs = errs | err_s;
      if (k == 0) begin
        we = ~w; addr = ~a; wdata = ~d;
      end
      k++;
    end
    rd = rdata_s;
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1;
    ack_low = !ack_s;
    errs = errs | err_s;
  endtask

  task automatic test_reset();
    int lat; logic [7:0] rd; logic errs, al; logic [7:0] exp;
    sel_z = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (ack_w !== 1'b0) begin failures++; $display("FAIL reset_ack_w got=%b exp=0", ack_w); end
    checks++; if (err_w !== 1'b0) begin failures++; $display("FAIL reset_err_w got=%b exp=0", err_w); end
    checks++; if (rdata_w !== 8'h00) begin failures++; $display("FAIL reset_rdata_w got=%h exp=00", rdata_w); end
    checks++; if (ack_z !== 1'b0) begin failures++; $display("FAIL reset_ack_z got=%b exp=0", ack_z); end
    checks++; if (rdata_z !== 8'h00) begin failures++; $display("FAIL reset_rdata_z got=%h exp=00", rdata_z); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      xfer(1'b0, 2'(a), 8'h00, lat, rd, errs, al);
      exp = (a == 0) ? REG0_RST : 8'h00;
      checks++; if (rd !== exp) begin failures++; $display("FAIL reset_read[%0d] got=%h exp=%h", a, rd, exp); end
      checks++; if (lat != 3) begin failures++; $display("FAIL reset_read_lat[%0d] got=%0d exp=3", a, lat); end
    end
  endtask

  task automatic test_write();
    int lat; logic [7:0] rd; logic errs, al;
    sel_z = 1'b0;
    xfer(1'b1, 2'd1, 8'h3C, lat, rd, errs, al);
    checks++; if (lat != 3) begin failures++; $display("FAIL write_lat got=%0d exp=3", lat); end
    checks++; if (al !== 1'b1) begin failures++; $display("FAIL write_ack_fall got=%b exp=1", al); end
    checks++; if (errs !== 1'b0) begin failures++; $display("FAIL write_err got=%b exp=0", errs); end
    xfer(1'b0, 2'd1, 8'h00, lat, rd, errs, al);
    checks++; if (rd !== 8'h3C) begin failures++; $display("FAIL read_back got=%h exp=3c", rd); end
    checks++; if (rdata_w !== 8'h3C) begin failures++; $display("FAIL rdata_hold got=%h exp=3c", rdata_w); end
    xfer(1'b1, 2'd0, 8'h55, lat, rd, errs, al);
    checks++; if (lat != 3) begin failures++; $display("FAIL reg0_write_lat got=%0d exp=3", lat); end
    checks++; if (errs !== 1'b0) begin failures++; $display("FAIL reg0_write_err got=%b exp=0", errs); end
    checks++; if (rdata_w !== 8'h3C) begin failures++; $display("FAIL rdata_after_write got=%h exp=3c", rdata_w); end
    xfer(1'b0, 2'd0, 8'h00, lat, rd, errs, al);
    checks++; if (rd !== REG0_WR) begin failures++; $display("FAIL reg0_read got=%h exp=%h", rd, REG0_WR); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [7:0] rd; logic errs, al;
    sel_z = 1'b1;
    for (int n = 0; n < 2; n++) begin
      xfer(1'b0, 2'd1, 8'h00, lat, rd, errs, al);
      checks++; if (lat != 1) begin failures++; $display("FAIL b2b_lat[%0d] got=%0d exp=1", n, lat); end
      checks++; if (rd !== 8'h3C) begin failures++; $display("FAIL b2b_rdata[%0d] got=%h exp=3c", n, rd); end
      checks++; if (al !== 1'b1) begin failures++; $display("FAIL b2b_ack_fall[%0d] got=%b exp=1", n, al); end
    end
    sel_z = 1'b0;
  endtask

  task automatic test_abort();
    int lat; logic [7:0] rd; logic errs, al;
    sel_z = 1'b0;
    xfer(1'b1, 2'd2, 8'h77, lat, rd, errs, al);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 2'd2; wdata = 8'h11;
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    checks++; if (err_w !== 1'b1) begin failures++; $display("FAIL abort_err got=%b exp=1", err_w); end
    checks++; if (ack_w !== 1'b0) begin failures++; $display("FAIL abort_ack got=%b exp=0", ack_w); end
    @(posedge clk); #1;
    checks++; if (err_w !== 1'b0) begin failures++; $display("FAIL abort_err_pulse got=%b exp=0", err_w); end
    checks++; if (ack_w !== 1'b0) begin failures++; $display("FAIL abort_ack_late got=%b exp=0", ack_w); end
    xfer(1'b0, 2'd2, 8'h00, lat, rd, errs, al);
    checks++; if (rd !== 8'h77) begin failures++; $display("FAIL abort_reg got=%h exp=77", rd); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [7:0] rd; logic errs, al;
    sel_z = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 2'd3; wdata = 8'hFF;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (ack_w !== 1'b1) begin failures++; $display("FAIL mid_ack_up got=%b exp=1", ack_w); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ack_w !== 1'b0) begin failures++; $display("FAIL mid_ack_reset got=%b exp=0", ack_w); end
    checks++; if (rdata_w !== 8'h00) begin failures++; $display("FAIL mid_rdata_reset got=%h exp=00", rdata_w); end
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1'b0, 2'd3, 8'h00, lat, rd, errs, al);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL mid_read3 got=%h exp=00", rd); end
    xfer(1'b0, 2'd1, 8'h00, lat, rd, errs, al);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL mid_read1 got=%h exp=00", rd); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
